// File: rtl/axil_slv_mem.sv
// rtl/axil_slv_mem.sv - AXI4-Lite slave memory with byte strobes and independent read/write FSMs
// Optional feature macro: AXIL_SLV_MEM_RANGE_CHK_EN (out-of-range addresses answer SLVERR)
module axil_slv_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * BYTES);
`ifdef AXIL_SLV_MEM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write channel state
  wstate_t           w_state, w_state_n;
  logic              aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_W-1:0] awaddr_q, awaddr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [BYTES-1:0]  wstrb_q, wstrb_n;
  logic              awready_n, wready_n, bvalid_n;
  logic [1:0]        bresp_n;
  logic              commit;

  // Read channel state
  rstate_t           r_state, r_state_n;
  logic              arready_n, rvalid_n;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        rresp_n;

  // A payload arriving this cycle is used directly so AW+W in one cycle commit on that edge
  logic              aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_oob, rd_oob;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign wr_addr = aw_hs ? s_axi_awaddr : awaddr_q;
  assign wr_data = w_hs ? s_axi_wdata : wdata_q;
  assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;
  assign wr_idx  = wr_addr[IDX_W+OFF_W-1:OFF_W];
  assign rd_idx  = s_axi_araddr[IDX_W+OFF_W-1:OFF_W];
  assign wr_oob  = RANGE_CHK && ({1'b0, wr_addr} >= MEM_BYTES);
  assign rd_oob  = RANGE_CHK && ({1'b0, s_axi_araddr} >= MEM_BYTES);

  // Write FSM: collect AW and W independently, commit once both are present, then hold B
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    awaddr_n  = awaddr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    awready_n = s_axi_awready;
    wready_n  = s_axi_wready;
    bvalid_n  = s_axi_bvalid;
    bresp_n   = s_axi_bresp;
    commit    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          awaddr_n  = s_axi_awaddr;
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          wdata_n  = s_axi_wdata;
          wstrb_n  = s_axi_wstrb;
        end
        if (aw_held_n && w_held_n) begin
          commit    = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = wr_oob ? SLVERR : OKAY;
          w_state_n = W_RESP;
        end else begin
          awready_n = !aw_held_n;
          wready_n  = !w_held_n;
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read FSM: register RAM word on AR handshake, hold R until accepted
  always_comb begin
    r_state_n = r_state;
    arready_n = s_axi_arready;
    rvalid_n  = s_axi_rvalid;
    rdata_n   = s_axi_rdata;
    rresp_n   = s_axi_rresp;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = rd_oob ? '0 : mem[rd_idx];
          rresp_n   = rd_oob ? SLVERR : OKAY;
          r_state_n = R_DATA;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Channel registers; reset drops every ready and discards held/pending transfers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
    end else begin
      w_state       <= w_state_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      awaddr_q      <= awaddr_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_bresp   <= bresp_n;
      r_state       <= r_state_n;
      s_axi_arready <= arready_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rdata   <= rdata_n;
      s_axi_rresp   <= rresp_n;
    end
  end

  // Byte-masked RAM write; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (commit && !wr_oob) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
